// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// uart_tx_fifo: parametrised UART transmitter with an input FIFO.
//   clk, reset_n          : clock, asynchronous active-low reset
//   tx_data_in, tx_valid  : word to queue and its qualifier
//   tx_ready              : FIFO not full (registered)
//   tx_data_out           : serial line, idle high (registered)
//   tx_busy               : frame in progress or FIFO non-empty (registered)
//   fifo_count            : FIFO occupancy
// Optional feature macro: UART_TX_BREAK_EN adds input tx_break (hold line low
// while idle; line is held high for a stop period before the next start bit).
module uart_tx_fifo #(
  parameter int unsigned CLK_DIV    = 10416,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_BITS-1:0]          tx_data_in,
  input  logic                          tx_valid,
`ifdef UART_TX_BREAK_EN
  input  logic                          tx_break,
`endif
  output logic                          tx_ready,
  output logic                          tx_data_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = 16;
  localparam int unsigned IW = 4;

  // Elaboration-time parameter checks
  if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_div
    $error("uart_tx_fifo: CLK_DIV out of range 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_fifo: DATA_BITS out of range 5..9");
  end
  if (PARITY > 2) begin : g_bad_par
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e               state_q;
  logic [BW-1:0]        baud_q;
  logic [IW-1:0]        bit_idx_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 brk_seen_q;
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 line_q, busy_q, ready_q;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic brk_c, bit_end_c, last_stop_c, push_c, pop_c, line_c;

`ifdef UART_TX_BREAK_EN
  assign brk_c = tx_break;
`else
  assign brk_c = 1'b0;
`endif

  assign bit_end_c   = (baud_q == BW'(CLK_DIV - 1));
  assign last_stop_c = (stop_idx_q == 1'(STOP_BITS - 1));
  assign push_c      = tx_valid && ready_q;
  // Pop from IDLE, or straight out of the last stop bit so frames abut
  assign pop_c = (count_q != '0) && !brk_c &&
                 ((state_q == S_IDLE && !brk_seen_q) ||
                  (state_q == S_STOP && bit_end_c && last_stop_c));

  // FIFO occupancy update
  always_comb begin
    count_d = count_q;
    if (push_c && !pop_c)      count_d = count_q + CW'(1);
    else if (!push_c && pop_c) count_d = count_q - CW'(1);
  end

  // Line level for the current state; registered below
  always_comb begin
    line_c = 1'b1;
    case (state_q)
      S_IDLE:   line_c = !brk_c;
      S_START:  line_c = 1'b0;
      S_DATA:   line_c = shift_q[0];
      S_PARITY: line_c = (PARITY == 2) ? !par_q : par_q;
      S_STOP:   line_c = 1'b1;
      default:  line_c = 1'b1;
    endcase
  end

  // FIFO storage (no reset needed on data)
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= tx_data_in;
  end

  // FSM, baud counter, FIFO pointers and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      brk_seen_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      line_q     <= 1'b1;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d < CW'(FIFO_DEPTH));
      busy_q  <= (state_q != S_IDLE) || (count_q != '0);
      line_q  <= line_c;
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        shift_q  <= mem_q[rd_ptr_q];
        par_q    <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          if (brk_c) begin
            brk_seen_q <= 1'b1;
          end else if (brk_seen_q) begin
            // After a break, reuse STOP as the guard period before any start bit
            brk_seen_q <= 1'b0;
            stop_idx_q <= 1'b0;
            state_q    <= S_STOP;
          end else if (pop_c) begin
            state_q <= S_START;
          end
        end
        S_START: begin
          if (bit_end_c) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= S_DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        S_DATA: begin
          if (bit_end_c) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            par_q   <= par_q ^ shift_q[0];
            if (bit_idx_q == IW'(DATA_BITS - 1)) begin
              stop_idx_q <= 1'b0;
              state_q    <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + IW'(1);
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        S_PARITY: begin
          if (bit_end_c) begin
            baud_q     <= '0;
            stop_idx_q <= 1'b0;
            state_q    <= S_STOP;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        S_STOP: begin
          if (bit_end_c) begin
            baud_q <= '0;
            if (last_stop_c) state_q <= pop_c ? S_START : S_IDLE;
            else             stop_idx_q <= 1'b1;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_data_out = line_q;
  assign tx_busy     = busy_q;
  assign tx_ready    = ready_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
// Directed testbench for uart_tx_fifo (CLK_DIV=4): 8N1, parity variants,
// FIFO fill/refusal with back-to-back frames, async reset, optional break.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] d0 = '0, dp = '0;
  logic       v0 = 1'b0, vp = 1'b0;
  logic       rdy0, line0, busy0;
  logic       rdy1, line1, busy1;
  logic       rdy2, line2, busy2;
  logic [2:0] cnt0, cnt1, cnt2;
`ifdef UART_TX_BREAK_EN
  logic       brk0 = 1'b0;
  logic       brk_off = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .tx_data_in(d0), .tx_valid(v0),
`ifdef UART_TX_BREAK_EN
    .tx_break(brk0),
`endif
    .tx_ready(rdy0), .tx_data_out(line0), .tx_busy(busy0), .fifo_count(cnt0));

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .tx_data_in(dp), .tx_valid(vp),
`ifdef UART_TX_BREAK_EN
    .tx_break(brk_off),
`endif
    .tx_ready(rdy1), .tx_data_out(line1), .tx_busy(busy1), .fifo_count(cnt1));

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .tx_data_in(dp), .tx_valid(vp),
`ifdef UART_TX_BREAK_EN
    .tx_break(brk_off),
`endif
    .tx_ready(rdy2), .tx_data_out(line2), .tx_busy(busy2), .fifo_count(cnt2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; sample point is 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    v0 = 1'b0;
    vp = 1'b0;
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] f8n1, fev, fod;
    logic [9:0]  fr;
    logic [7:0]  fd [5];
    logic        e, seen_low;
    int          u;

    // Frames listed LSB first: start, data, [parity], stop(s)
    f8n1 = {6'b0, 1'b1, 8'hA5, 1'b0};          // 0x034A
    fev  = {4'b0, 2'b11, 1'b0, 8'hA5, 1'b0};   // even parity 0, two stops
    fod  = {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0};    // odd parity 1, one stop
    fd   = '{8'h11, 8'h3C, 8'hC3, 8'h81, 8'h7E};

    // Reset and idle
    do_reset();
    step();
    check("rst_line", 32'(line0), 32'(1'b1));
    check("rst_ready", 32'(rdy0), 32'(1'b1));
    check("rst_count", 32'(cnt0), 32'd0);
    check("rst_busy", 32'(busy0), 32'(1'b0));

    // 8N1 frame of 0xA5; push lands at edge N (t=0)
    d0 = 8'hA5; v0 = 1'b1;
    step();
    v0 = 1'b0;
    check("8n1_cnt_push", 32'(cnt0), 32'd1);
    for (int t = 1; t <= 46; t++) begin
      step();
      e = (t >= 2 && t < 42) ? f8n1[(t - 2) / 4] : 1'b1;
      check("8n1_line", 32'(line0), 32'(e));
      check("8n1_busy", 32'(busy0), 32'(t <= 41));
      if (t == 1) check("8n1_cnt_pop", 32'(cnt0), 32'd0);
    end

    // Even parity + 2 stop bits (dut1), odd parity + 1 stop (dut2)
    do_reset();
    dp = 8'hA5; vp = 1'b1;
    step();
    vp = 1'b0;
    for (int t = 1; t <= 56; t++) begin
      step();
      e = (t >= 2 && t < 50) ? fev[(t - 2) / 4] : 1'b1;
      check("even_line", 32'(line1), 32'(e));
      e = (t >= 2 && t < 46) ? fod[(t - 2) / 4] : 1'b1;
      check("odd_line", 32'(line2), 32'(e));
      if (t == 40) begin
        check("even_par_bit", 32'(line1), 32'(1'b0));
        check("odd_par_bit", 32'(line2), 32'(1'b1));
      end
      if (t == 49) check("stop2_busy_hi", 32'(busy1), 32'(1'b1));
      if (t == 50) check("stop2_busy_lo", 32'(busy1), 32'(1'b0));
      if (t == 45) check("odd_busy_hi", 32'(busy2), 32'(1'b1));
      if (t == 46) check("odd_busy_lo", 32'(busy2), 32'(1'b0));
    end

    // FIFO fill, refusal while full (including at the pop edge), back-to-back frames
    do_reset();
    d0 = fd[0]; v0 = 1'b1;
    step();
    v0 = 1'b0;
    for (int t = 1; t <= 212; t++) begin
      v0 = 1'b0;
      if (t >= 3 && t <= 6) begin
        v0 = 1'b1; d0 = fd[t - 2];
      end else if (t >= 7 && t <= 41) begin
        v0 = 1'b1; d0 = 8'hFF;
      end
      step();
      if (t >= 2 && t < 202) begin
        u  = t - 2;
        fr = {1'b1, fd[u / 40], 1'b0};
        e  = fr[(u % 40) / 4];
      end else begin
        e = 1'b1;
      end
      check("fifo_line", 32'(line0), 32'(e));
      if (t == 6) begin
        check("full_cnt", 32'(cnt0), 32'd4);
        check("full_ready", 32'(rdy0), 32'(1'b0));
      end
      if (t == 40) check("full_refuse_cnt", 32'(cnt0), 32'd4);
      if (t == 41) begin
        check("pop_full_cnt", 32'(cnt0), 32'd3);
        check("pop_full_ready", 32'(rdy0), 32'(1'b1));
      end
    end
    v0 = 1'b0;
    check("fifo_end_cnt", 32'(cnt0), 32'd0);
    check("fifo_end_busy", 32'(busy0), 32'(1'b0));

    // Asynchronous reset during data bit 3 of 0x00
    do_reset();
    d0 = 8'h00; v0 = 1'b1;
    step();
    v0 = 1'b0;
    repeat (19) step();
    check("bit3_low", 32'(line0), 32'(1'b0));
    #2 reset_n = 1'b0;
    #1;
    check("async_line", 32'(line0), 32'(1'b1));
    check("async_busy", 32'(busy0), 32'(1'b0));
    check("async_cnt", 32'(cnt0), 32'd0);
    check("async_ready", 32'(rdy0), 32'(1'b1));
    #2 reset_n = 1'b1;
    seen_low = 1'b0;
    repeat (60) begin
      step();
      if (!line0) seen_low = 1'b1;
    end
    check("no_residual", 32'(seen_low), 32'(1'b0));
    check("post_rst_cnt", 32'(cnt0), 32'd0);

`ifdef UART_TX_BREAK_EN
    begin
      int  hi;
      logic done;
      do_reset();
      brk0 = 1'b1;
      d0 = 8'h55; v0 = 1'b1;
      step();
      v0 = 1'b0;
      for (int i = 0; i < 20; i++) begin
        step();
        check("brk_line", 32'(line0), 32'(1'b0));
      end
      check("brk_cnt", 32'(cnt0), 32'd1);
      brk0 = 1'b0;
      hi = 0;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
        step();
        if (line0) hi++;
        else       done = 1'b1;
      end
      check("brk_start_seen", 32'(done), 32'(1'b1));
      check("brk_guard_len", 32'(hi >= 4), 32'(1'b1));
      fr = {1'b1, 8'h55, 1'b0};
      for (int c = 1; c < 40; c++) begin
        step();
        check("brk_frame", 32'(line0), 32'(fr[c / 4]));
      end
      check("brk_end_cnt", 32'(cnt0), 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
